pipe_stage_reg: RTL and testbench

Parametrised, elastic inter-stage pipeline register for the five-stage CPU datapath. It replaces the fixed E→M/D→E register style with a single generic block. The block carries a packed payload of configurable width under a valid/ready handshake, with an optional skid entry and a synchronous flush that inserts a bubble. Every stage boundary (F→D, D→E, E→M, M→W) instantiates it with the payload width for that boundary.

---
 rtl/pipe_pkg.sv | 64 ++++++
 rtl/pipe_stage_reg_slot.sv | 42 ++++
 rtl/pipe_stage_reg.sv | 107 ++++++++++
 tb/tb_pipe_stage_reg.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared datapath constants for the five-stage CPU pipeline:
//                field widths, per-boundary payload widths, field offsets and
//                the E->M bundle layout.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

  // Field widths
  localparam int INSTR_W = 32;
  localparam int A3_W    = 5;
  localparam int PC_W    = 32;
  localparam int DATA_W  = 32;

  // Per-boundary payload widths
  localparam int FD_W = PC_W + A3_W;                        // 37
  localparam int DE_W = INSTR_W + A3_W + PC_W + 2*DATA_W;   // 133
  localparam int EM_W = INSTR_W + A3_W + PC_W + 2*DATA_W;   // 133
  localparam int MW_W = A3_W + PC_W + 2*DATA_W;             // 101

  // F->D field offsets (LSB positions)
  localparam int FD_A3_LSB = 0;
  localparam int FD_PC_LSB = FD_A3_LSB + A3_W;

  // E->M field offsets (LSB positions), RD2 in the low bits, Instr on top
  localparam int EM_RD2_LSB   = 0;
  localparam int EM_ALU_LSB   = EM_RD2_LSB + DATA_W;
  localparam int EM_PC_LSB    = EM_ALU_LSB + DATA_W;
  localparam int EM_A3_LSB    = EM_PC_LSB + PC_W;
  localparam int EM_INSTR_LSB = EM_A3_LSB + A3_W;

  // An all-zero instruction word decodes as a nop, so a zeroed payload is a bubble
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  // E->M bundle in the same bit order as the offsets above
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [A3_W-1:0]    a3;
    logic [PC_W-1:0]    pc;
    logic [DATA_W-1:0]  alu_out;
    logic [DATA_W-1:0]  rd2;
  } em_bundle_t;

  // Pack E->M fields into a flat payload
  function automatic logic [EM_W-1:0] em_pack(
    input logic [INSTR_W-1:0] instr,
    input logic [A3_W-1:0]    a3,
    input logic [PC_W-1:0]    pc,
    input logic [DATA_W-1:0]  alu_out,
    input logic [DATA_W-1:0]  rd2
  );
    em_bundle_t b;
    b.instr   = instr;
    b.a3      = a3;
    b.pc      = pc;
    b.alu_out = alu_out;
    b.rd2     = rd2;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_slot.sv
`default_nettype none
// ============================================================================
//  Module      : stage_slot
//  Description : One pipeline entry: valid bit plus payload register with
//                load, clear-to-zero and asynchronous active-low reset.
//                Clear wins over load.
//  Revision    : 1.0  initial release
// ============================================================================
module stage_slot #(
  parameter int WIDTH = 133
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Hold one entry; an empty entry always carries an all-zero payload (bubble)
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (clear) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= d;
    end
  end

  assign valid = r_valid;
  assign q     = r_data;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Elastic inter-stage pipeline register with valid/ready
//                handshake, optional skid entry (registered in_ready) and a
//                synchronous flush that leaves a zero bubble behind.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = EM_W,
  parameter bit SKID  = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       count
);

  logic             w_accept;
  logic             w_consume;
  logic             w_main_valid;
  logic [WIDTH-1:0] w_main_data;
  logic             w_main_load;
  logic             w_main_clear;
  logic [WIDTH-1:0] w_main_d;
  logic             w_skid_valid;

  assign w_accept  = in_valid && in_ready;
  assign w_consume = w_main_valid && out_ready;

  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  assign count     = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

  stage_slot #(.WIDTH(WIDTH)) u_main (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .load    (w_main_load),
    .clear   (w_main_clear),
    .d       (w_main_d),
    .valid   (w_main_valid),
    .q       (w_main_data)
  );

  generate
    if (SKID) begin : g_skid
      logic             w_skid_load;
      logic             w_skid_clear;
      logic [WIDTH-1:0] w_skid_data;
      logic             w_skid_next;
      logic             r_in_ready;

      // Main takes new data when it is free (or freed this cycle); otherwise
      // the skid entry refills main as soon as main is consumed.
      assign w_main_load  = !flush &&
                            ((w_accept && (!w_main_valid || w_consume)) ||
                             (w_consume && w_skid_valid));
      assign w_main_d     = (w_consume && w_skid_valid) ? w_skid_data : in_data;
      assign w_main_clear = flush || (w_consume && !w_main_load);

      // Skid catches the one payload accepted while main is stalled
      assign w_skid_load  = !flush && w_accept && w_main_valid && !w_consume;
      assign w_skid_clear = flush || (w_consume && w_skid_valid);
      assign w_skid_next  = (w_skid_valid && !w_consume) || w_skid_load;

      stage_slot #(.WIDTH(WIDTH)) u_skid (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (w_skid_load),
        .clear   (w_skid_clear),
        .d       (in_data),
        .valid   (w_skid_valid),
        .q       (w_skid_data)
      );

      // in_ready is registered as the complement of the next skid occupancy
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          r_in_ready <= 1'b1;
        end else if (flush) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= !w_skid_next;
        end
      end

      assign in_ready = r_in_ready;
    end else begin : g_noskid
      // Single entry: ready whenever the held payload leaves this cycle
      assign in_ready     = out_ready || !w_main_valid;
      assign w_main_load  = !flush && w_accept;
      assign w_main_d     = in_data;
      assign w_main_clear = flush || (w_consume && !w_main_load);
      assign w_skid_valid = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench for pipe_stage_reg, SKID=1 and SKID=0
//                instances at WIDTH=37, compared against a queue model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int W = 37;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         flush;
  logic         out_ready1, out_ready0;

  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [1:0]   count1;
  logic         in_ready0, out_valid0;
  logic [W-1:0] out_data0;
  logic [1:0]   count0;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  pipe_stage_reg #(.WIDTH(W), .SKID(1'b1)) dut_s1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .flush(flush), .count(count1)
  );

  pipe_stage_reg #(.WIDTH(W), .SKID(1'b0)) dut_s0 (
    .Clk(Clk), .Reset_n(Reset_n),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .flush(flush), .count(count0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of capacity 2 (skid) or 1 (no skid)
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];

  function automatic bit m_ready1();
    return q1.size() < 2;
  endfunction
  function automatic bit m_ready0();
    return out_ready0 || (q0.size() == 0);
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    bit acc1, con1, acc0, con0;
    if (!Reset_n) begin
      q1.delete();
      q0.delete();
    end else if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      acc1 = in_valid && m_ready1();
      con1 = out_ready1 && (q1.size() > 0);
      acc0 = in_valid && m_ready0();
      con0 = out_ready0 && (q0.size() > 0);
      if (con1) void'(q1.pop_front());
      if (acc1) q1.push_back(in_data);
      if (con0) void'(q0.pop_front());
      if (acc0) q0.push_back(in_data);
    end
  end

  // Every-cycle comparison against the model, away from the rising edge
  always @(negedge Clk) begin
    chk("s1_out_valid", 64'(out_valid1), 64'(q1.size() > 0));
    chk("s1_out_data",  64'(out_data1),  (q1.size() > 0) ? 64'(q1[0]) : 64'd0);
    chk("s1_count",     64'(count1),     64'(q1.size()));
    chk("s1_in_ready",  64'(in_ready1),  64'(m_ready1()));
    chk("s0_out_valid", 64'(out_valid0), 64'(q0.size() > 0));
    chk("s0_out_data",  64'(out_data0),  (q0.size() > 0) ? 64'(q0[0]) : 64'd0);
    chk("s0_count",     64'(count0),     64'(q0.size()));
    chk("s0_in_ready",  64'(in_ready0),  64'(m_ready0()));
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    in_valid   = 1'b0;
    flush      = 1'b0;
    out_ready1 = 1'b1;
    out_ready0 = 1'b1;
    step();
    step();
  endtask

  initial begin
    Reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    flush      = 1'b0;
    out_ready1 = 1'b0;
    out_ready0 = 1'b0;

    // Reset held for three cycles
    step(); step(); step();
    Reset_n = 1'b1;
    chk("rst_s1_out_valid", 64'(out_valid1), 64'd0);
    chk("rst_s1_out_data",  64'(out_data1),  64'd0);
    chk("rst_s1_count",     64'(count1),     64'd0);
    chk("rst_s1_in_ready",  64'(in_ready1),  64'd1);
    chk("rst_s0_out_valid", 64'(out_valid0), 64'd0);

    // Streaming 1..8 with out_ready high
    out_ready1 = 1'b1;
    out_ready0 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      step();
      chk("stream_s1_data",  64'(out_data1), 64'(i));
      chk("stream_s1_count", 64'(count1),    64'd1);
      chk("stream_s0_data",  64'(out_data0), 64'(i));
    end
    drain();

    // Back-pressure: A then B with out_ready low
    out_ready1 = 1'b0;
    out_ready0 = 1'b0;
    in_valid   = 1'b1;
    in_data    = W'('h0A);
    step();
    in_data = W'('h0B);
    step();
    chk("stall_s1_count",    64'(count1),    64'd2);
    chk("stall_s1_in_ready", 64'(in_ready1), 64'd0);
    chk("stall_s1_data",     64'(out_data1), 64'h0A);
    chk("stall_s0_count",    64'(count0),    64'd1);
    chk("stall_s0_data",     64'(out_data0), 64'h0A);
    in_valid   = 1'b0;
    out_ready1 = 1'b1;
    out_ready0 = 1'b1;
    step();
    chk("unstall_s1_data",     64'(out_data1),  64'h0B);
    chk("unstall_s1_in_ready", 64'(in_ready1),  64'd1);
    chk("unstall_s0_valid",    64'(out_valid0), 64'd0);
    drain();

    // Flush with count=2 and a payload C presented in the same cycle
    out_ready1 = 1'b0;
    out_ready0 = 1'b0;
    in_valid   = 1'b1;
    in_data    = W'('h0A);
    step();
    in_data = W'('h0B);
    step();
    flush   = 1'b1;
    in_data = W'('h0C);
    step();
    chk("flush_s1_valid",    64'(out_valid1), 64'd0);
    chk("flush_s1_data",     64'(out_data1),  64'd0);
    chk("flush_s1_count",    64'(count1),     64'd0);
    chk("flush_s1_in_ready", 64'(in_ready1),  64'd1);
    chk("flush_s0_valid",    64'(out_valid0), 64'd0);
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready1 = 1'b1;
    out_ready0 = 1'b1;
    step();
    chk("flush_no_c_s1", 64'(out_valid1), 64'd0);
    chk("flush_no_c_s0", 64'(out_valid0), 64'd0);

    // Asynchronous reset between edges while two entries are held
    out_ready1 = 1'b0;
    out_ready0 = 1'b0;
    in_valid   = 1'b1;
    in_data    = W'('h11);
    step();
    in_data = W'('h22);
    step();
    in_valid = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("arst_s1_valid",    64'(out_valid1), 64'd0);
    chk("arst_s1_data",     64'(out_data1),  64'd0);
    chk("arst_s1_count",    64'(count1),     64'd0);
    chk("arst_s1_in_ready", 64'(in_ready1),  64'd1);
    chk("arst_s0_data",     64'(out_data0),  64'd0);
    step(); step();
    Reset_n    = 1'b1;
    out_ready1 = 1'b1;
    out_ready0 = 1'b1;
    in_valid   = 1'b1;
    in_data    = W'('h33);
    step();
    chk("restart_s1_data", 64'(out_data1), 64'h33);
    chk("restart_s0_data", 64'(out_data0), 64'h33);

    // Full-width patterns
    in_data = 37'h1F_FFFF_FFFF;
    step();
    chk("width_ones_s1", 64'(out_data1), 64'h1F_FFFF_FFFF);
    chk("width_ones_s0", 64'(out_data0), 64'h1F_FFFF_FFFF);
    in_data = 37'h00_0000_0001;
    step();
    chk("width_one_s1", 64'(out_data1), 64'h1);
    chk("width_one_s0", 64'(out_data0), 64'h1);
    drain();

    // Randomised traffic checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = W'({$urandom, $urandom});
      out_ready1 = ($urandom_range(0, 2) == 0);
      out_ready0 = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 24) == 0);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
